// File: rtl/pagerank_scatter.sv
// PageRank scatter stage: divides each node's rank by its out-degree into a contribution
// table, then streams one (contribution, destination) beat per in-range edge.
module pagerank_scatter #(
  parameter int unsigned NODES_IN_GRAPH = 4,
  parameter int unsigned SRC_WIDTH      = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              nextIteration,
  input  logic [NODES_IN_GRAPH-1:0][63:0]   pagerank_current,
  input  logic [NODES_IN_GRAPH-1:0][31:0]   out_degree,
  input  logic                              edge_valid,
  input  logic [SRC_WIDTH-1:0]              edge_src,
  input  logic [31:0]                       edge_dst,
  input  logic                              edge_last,
  output logic                              edge_ready,
  output logic [63:0]                       page_rank_scatter,
  output logic [31:0]                       dest_id,
  output logic                              pagerank_ready,
  output logic                              pagerank_enable,
  output logic                              scatter_operation_complete,
  output logic                              busy,
  output logic                              error_flag
);

  localparam int unsigned IDX_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;

  typedef enum logic [1:0] {StIdle, StDivide, StStream, StDone} state_t;

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_node;
  logic [5:0]       r_cnt;
  logic [63:0]      r_quot;
  logic [31:0]      r_rem;
  logic [63:0]      r_contrib [NODES_IN_GRAPH];
  logic             r_ready;
  logic [63:0]      r_scatter;
  logic [31:0]      r_dest;
  logic             r_complete;
  logic             r_error;

  logic        w_start, w_last_node, w_trivial, w_step_done, w_accept, w_in_range, w_emit;
  logic        w_ge;
  logic [31:0] w_deg, w_rem_in, w_rem_next;
  logic [63:0] w_rank, w_div_src, w_quot_next, w_contrib_val;
  logic [32:0] w_shift;

  assign w_start     = nextIteration && (r_state == StIdle || r_state == StDone);
  assign w_last_node = (r_node == IDX_W'(NODES_IN_GRAPH - 1));
  assign w_deg       = out_degree[r_node];
  assign w_rank      = pagerank_current[r_node];
  assign w_trivial   = (w_deg <= 32'd1);
  assign w_step_done = w_trivial || (r_cnt == 6'd63);
  assign w_accept    = (r_state == StStream) && edge_valid;
  assign w_in_range  = (edge_src < SRC_WIDTH'(NODES_IN_GRAPH)) &&
                       (edge_dst < 32'(NODES_IN_GRAPH));
  assign w_emit      = w_accept && w_in_range;

  // First step of a node takes the dividend straight from the rank input.
  assign w_div_src   = (r_cnt == 6'd0) ? w_rank : r_quot;
  assign w_rem_in    = (r_cnt == 6'd0) ? 32'd0 : r_rem;
  assign w_shift     = {w_rem_in, w_div_src[63]};
  assign w_ge        = (w_shift >= {1'b0, w_deg});
  assign w_rem_next  = w_ge ? 32'(w_shift - {1'b0, w_deg}) : w_shift[31:0];
  assign w_quot_next = {w_div_src[62:0], w_ge};
  assign w_contrib_val = (w_deg == 32'd0) ? 64'd0 :
                         (w_deg == 32'd1) ? w_rank : w_quot_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: if (nextIteration) w_state_next = StDivide;
      StDivide:       if (w_step_done && w_last_node) w_state_next = StStream;
      StStream:       if (w_accept && edge_last) w_state_next = StDone;
      default:        w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_node <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      for (int i = 0; i < int'(NODES_IN_GRAPH); i++) r_contrib[i] <= '0;
    end else if (w_start) begin
      r_node <= '0;
      r_cnt  <= '0;
    end else if (r_state == StDivide) begin
      if (w_step_done) begin
        r_contrib[r_node] <= w_contrib_val;
        r_cnt             <= '0;
        if (!w_last_node) r_node <= r_node + 1'b1;
      end else begin
        r_cnt  <= r_cnt + 6'd1;
        r_quot <= w_quot_next;
        r_rem  <= w_rem_next;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ready    <= 1'b0;
      r_scatter  <= '0;
      r_dest     <= '0;
      r_complete <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_ready <= w_emit;
      if (w_emit) begin
        r_scatter <= r_contrib[edge_src[IDX_W-1:0]];
        r_dest    <= edge_dst;
      end
      if (w_start) begin
        r_complete <= 1'b0;
        r_error    <= 1'b0;
      end else begin
        if (w_accept && edge_last)   r_complete <= 1'b1;
        if (w_accept && !w_in_range) r_error    <= 1'b1;
      end
    end
  end

  assign edge_ready                 = (r_state == StStream);
  assign pagerank_enable            = (r_state == StStream) || (r_state == StDone);
  assign busy                       = (r_state == StDivide) || (r_state == StStream);
  assign page_rank_scatter          = r_scatter;
  assign dest_id                    = r_dest;
  assign pagerank_ready             = r_ready;
  assign scatter_operation_complete = r_complete;
  assign error_flag                 = r_error;

endmodule

// File: doc/pagerank_scatter.md
Name: pagerank_scatter

Overview:
Scatter stage feeding pagerank_local_update. At the start of each iteration it computes every node's per-edge contribution, rank / out-degree, with a sequential divider and stores it in a contribution table. It then consumes the partition's edge stream and emits one (page_rank_scatter, dest_id, pagerank_ready) beat per valid edge. It flags scatter_operation_complete after the last edge.

Parameters:
NODES_IN_GRAPH, 4, number of nodes; sizes the rank, degree and contribution tables.
SRC_WIDTH, 32, width of edge_src; must be at least clog2(NODES_IN_GRAPH).

Ports:
clock  input  1  single clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
nextIteration  input  1  start pulse; honoured only in IDLE or DONE.
pagerank_current  input  64 x NODES_IN_GRAPH  unsigned fixed-point ranks for this iteration.
out_degree  input  32 x NODES_IN_GRAPH  out-degree per node.
edge_valid  input  1  edge stream valid.
edge_src  input  SRC_WIDTH  edge source node.
edge_dst  input  32  edge destination node.
edge_last  input  1  marks the final edge of the iteration.
edge_ready  output  1  edge accepted when edge_valid and edge_ready are both high.
page_rank_scatter  output  64  contribution of edge_src.
dest_id  output  32  edge_dst of the emitted beat.
pagerank_ready  output  1  one-cycle valid for the emitted beat.
pagerank_enable  output  1  high while in STREAM or DONE.
scatter_operation_complete  output  1  held high from the last beat until the next start.
busy  output  1  high in DIVIDE or STREAM.
error_flag  output  1  sticky; set when an out-of-range edge is dropped.

Behaviour:
- Reset: the FSM goes to IDLE. Every output is 0. The contribution table and divider registers are cleared. A reset asserted mid-DIVIDE or mid-STREAM aborts immediately, and no partial beat is emitted.
- FSM states: IDLE, DIVIDE, STREAM, DONE.
- IDLE or DONE with nextIteration=1: go to DIVIDE with node index 0. Clear scatter_operation_complete and error_flag.
- nextIteration while in DIVIDE or STREAM is ignored.
- DIVIDE, per node i in ascending order:
  - out_degree[i]==0: contribution is 0 (dangling node). Takes 1 cycle.
  - out_degree[i]==1: contribution is pagerank_current[i]. Takes 1 cycle.
  - Otherwise: restoring divide, 1 quotient bit per cycle, exactly 64 cycles; contribution = floor(rank / degree).
  - After node NODES_IN_GRAPH-1, go to STREAM.
- Inputs pagerank_current and out_degree must stay stable from the start pulse until DIVIDE exits.
- STREAM:
  - edge_ready=1 every cycle; no backpressure from downstream.
  - On an accepted edge, the next cycle shows pagerank_ready=1, page_rank_scatter=contrib[edge_src], dest_id=edge_dst. Latency is 1 cycle and throughput is 1 edge per cycle.
  - pagerank_ready is 0 on any cycle that follows no accepted edge. page_rank_scatter and dest_id hold their last values.
  - edge_src >= NODES_IN_GRAPH or edge_dst >= NODES_IN_GRAPH: the edge is accepted but dropped. No beat is emitted and error_flag is set.
- Last edge: on the beat for an accepted edge_last edge, scatter_operation_complete rises in the same cycle as that beat's pagerank_ready. The FSM then enters DONE, and edge_ready drops the cycle after acceptance.
- Dropped last edge: if the edge_last edge is itself dropped, scatter_operation_complete still rises one cycle after acceptance, with pagerank_ready=0.
- DONE: scatter_operation_complete stays 1 and pagerank_enable stays 1 until the next start pulse.
- Widths and arithmetic: all arithmetic is unsigned with no rounding.

Test Plan:
1. Ranks [100,90,60,0], degrees [2,3,0,1], pulse nextIteration -> busy for 64+64+1+1=130 cycles, then edge_ready=1; contributions are [50,30,0,0].
2. Continue test 1 with back-to-back edges 0->2, 1->2, 1->0, 3->1 (last) -> beats (50,2), (30,2), (30,0), (0,1) on 4 consecutive cycles. scatter_operation_complete=1 coincides with the (0,1) beat and stays high.
3. Edge stream with idle gaps (edge_valid toggling 1,0,1) -> pagerank_ready follows one cycle later as 1,0,1; no duplicate beats.
4. Edge with src=7 in the middle of the stream, plus a final last edge 9->0 -> both edges dropped, error_flag=1, no beat for either. scatter_operation_complete rises the cycle after the last edge is accepted.
5. Assert reset during STREAM after 2 beats -> all outputs are 0 in the same cycle (asynchronous). After release, the FSM is in IDLE and nextIteration restarts DIVIDE from node 0.
6. nextIteration pulsed during DIVIDE -> ignored; DIVIDE cycle count unchanged. A pulse in DONE clears scatter_operation_complete and restarts DIVIDE.
